// File: rtl/rally_ctrl.sv
// Match sequencer for the two-player volleyball game: serve, rally, point, game over.
// Ports: clk, rst (sync, active-high), start, pause, ball_x/ball_y in;
//   phys_en, ball_reset, serve_side, score_l, score_r, winner, state out (all registered).
// Optional: define RALLY_CTRL_DEUCE_EN to require a 2-point lead to win.
module rally_ctrl #(
  parameter logic [9:0] NET_X        = 10'd160,
  parameter logic [9:0] FLOOR_Y      = 10'd220,
  parameter int         SERVE_FRAMES = 30,
  parameter int         POINT_FRAMES = 45,
  parameter int         WIN_SCORE    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       phys_en,
  output logic       ball_reset,
  output logic       serve_side,
  output logic [4:0] score_l,
  output logic [4:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
  localparam logic [5:0] POINT_LAST = 6'(POINT_FRAMES - 1);
  localparam logic [5:0] WIN        = 6'(WIN_SCORE);

  state_t     st, nst;
  logic [5:0] cnt;
  logic       landed, left_pt;
  logic       win_l, win_r;
  logic [4:0] nl, nr;

  assign state   = st;
  assign landed  = !pause && (ball_y >= FLOOR_Y);
  // ball exactly on the net line counts as the right court
  assign left_pt = (ball_x >= NET_X);

`ifdef RALLY_CTRL_DEUCE_EN
  assign win_l = ({1'b0, score_l} >= WIN) &&
                 ({1'b0, score_l} >= {1'b0, score_r} + 6'd2);
  assign win_r = ({1'b0, score_r} >= WIN) &&
                 ({1'b0, score_r} >= {1'b0, score_l} + 6'd2);
`else
  assign win_l = ({1'b0, score_l} >= WIN);
  assign win_r = ({1'b0, score_r} >= WIN);
`endif

  // scores after a landing, saturating at 31
  always_comb begin
    nl = score_l;
    nr = score_r;
    if (left_pt) nl = (score_l == 5'd31) ? score_l : score_l + 5'd1;
    else         nr = (score_r == 5'd31) ? score_r : score_r + 5'd1;
`ifdef RALLY_CTRL_DEUCE_EN
    // tie at the winning score folds back one point to keep counters bounded
    if (nl == nr && {1'b0, nl} == WIN) begin
      nl = 5'(WIN_SCORE - 1);
      nr = 5'(WIN_SCORE - 1);
    end
`endif
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:  if (start) nst = SERVE;
      SERVE: if (!pause && cnt == SERVE_LAST) nst = RALLY;
      RALLY: if (landed) nst = POINT;
      POINT: if (!pause && cnt == POINT_LAST)
               nst = (win_l || win_r) ? OVER : SERVE;
      OVER:  if (start) nst = SERVE;
      default: nst = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      phys_en    <= 1'b0;
      ball_reset <= 1'b1;
      serve_side <= 1'b0;
      score_l    <= '0;
      score_r    <= '0;
      winner     <= 2'b00;
    end else begin
      st         <= nst;
      phys_en    <= (nst == RALLY) && !pause;
      ball_reset <= (nst == IDLE) || (nst == SERVE) || (nst == OVER);
      unique case (st)
        IDLE, OVER: begin
          if (start) begin
            score_l    <= '0;
            score_r    <= '0;
            serve_side <= 1'b0;
            cnt        <= '0;
            winner     <= 2'b00;
          end
        end
        SERVE: begin
          if (!pause) cnt <= (cnt == SERVE_LAST) ? 6'd0 : cnt + 6'd1;
        end
        RALLY: begin
          if (landed) begin
            score_l    <= nl;
            score_r    <= nr;
            serve_side <= !left_pt;
            cnt        <= '0;
          end
        end
        POINT: begin
          if (!pause) begin
            if (cnt == POINT_LAST) begin
              cnt    <= '0;
              winner <= win_l ? 2'b01 : (win_r ? 2'b10 : 2'b00);
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rally_ctrl.sv
// Directed self-checking bench for rally_ctrl.
// Covers serve/rally/point timing, landing sides, pause, win and reset.
module tb_rally_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [9:0] ball_x, ball_y;
  logic       phys_en, ball_reset, serve_side;
  logic [4:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  rally_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .ball_x(ball_x), .ball_y(ball_y),
    .phys_en(phys_en), .ball_reset(ball_reset), .serve_side(serve_side),
    .score_l(score_l), .score_r(score_r), .winner(winner), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // counts cycles spent in state s, bounded
  task automatic wait_leave(input logic [2:0] s, output int cnt);
    cnt = 0;
    while (state === s && cnt < 300) begin
      tick();
      cnt++;
    end
    if (cnt >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout in state %0d: observed %0d cycles expected <300", s, cnt);
    end
  endtask

  // finishes any pending point/serve, then lands the ball at x
  task automatic run_point(input logic [9:0] x);
    int c;
    wait_leave(3'd3, c);
    wait_leave(3'd1, c);
    ball_x = x;
    ball_y = 10'd230;
    tick();
    ball_y = 10'd0;
    wait_leave(3'd3, c);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    ball_x = 10'd0; ball_y = 10'd0;
    tick();
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_phys", phys_en, 0);
    chk("rst_ballrst", ball_reset, 1);
    chk("rst_side", serve_side, 0);
    chk("rst_scl", score_l, 0);
    chk("rst_scr", score_r, 0);
    chk("rst_win", winner, 0);
    tick();
    chk("idle_hold", state, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", state, 1);
    chk("serve_ballrst", ball_reset, 1);
    chk("serve_phys", phys_en, 0);
    wait_leave(3'd1, n);
    chk("serve_len", n, 30);
    chk("rally_state", state, 2);
    chk("rally_phys", phys_en, 1);
    chk("rally_ballrst", ball_reset, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ign_rally", state, 2);

    // left-court landing; ball stays on floor through POINT
    ball_x = 10'd100;
    ball_y = 10'd220;
    tick();
    chk("pt1_scr", score_r, 1);
    chk("pt1_scl", score_l, 0);
    chk("pt1_side", serve_side, 1);
    chk("pt1_state", state, 3);
    chk("pt1_phys", phys_en, 0);
    chk("pt1_ballrst", ball_reset, 0);
    wait_leave(3'd3, n);
    chk("point_len", n, 45);
    chk("pt1_to_serve", state, 1);
    chk("pt1_floor_ign", score_r, 1);
    ball_y = 10'd0;
    wait_leave(3'd1, n);
    chk("serve_len2", n, 30);

    // ball on the net line: left scores
    ball_x = 10'd160;
    ball_y = 10'd230;
    tick();
    ball_y = 10'd0;
    chk("pt2_scl", score_l, 1);
    chk("pt2_scr", score_r, 1);
    chk("pt2_side", serve_side, 0);
    chk("pt2_state", state, 3);
    wait_leave(3'd3, n);
    chk("point_len2", n, 45);

    // pause mid-serve at counter 5
    repeat (5) tick();
    pause = 1'b1;
    repeat (10) tick();
    chk("pause_state", state, 1);
    chk("pause_phys", phys_en, 0);
    pause = 1'b0;
    wait_leave(3'd1, n);
    chk("serve_after_pause", n, 25);
    chk("pause_rally", state, 2);

    // pause in rally masks a landing until released
    pause = 1'b1;
    ball_x = 10'd50;
    ball_y = 10'd220;
    tick();
    chk("rpause_phys", phys_en, 0);
    tick();
    chk("rpause_state", state, 2);
    chk("rpause_scr", score_r, 1);
    pause = 1'b0;
    tick();
    ball_y = 10'd0;
    chk("rrel_scr", score_r, 2);
    chk("rrel_state", state, 3);

`ifdef RALLY_CTRL_DEUCE_EN
    repeat (13) run_point(10'd200);
    repeat (12) run_point(10'd50);
    chk("d_setup_l", score_l, 14);
    chk("d_setup_r", score_r, 14);
    run_point(10'd50);
    chk("d1_l", score_l, 14);
    chk("d1_r", score_r, 15);
    chk("d1_win", winner, 0);
    chk("d1_state", state, 1);
    run_point(10'd200);
    chk("d2_l", score_l, 14);
    chk("d2_r", score_r, 14);
    run_point(10'd50);
    run_point(10'd50);
    chk("d3_state", state, 4);
    chk("d3_win", winner, 2);
    chk("d3_l", score_l, 14);
    chk("d3_r", score_r, 16);
`else
    repeat (14) run_point(10'd200);
    chk("w_state", state, 4);
    chk("w_win", winner, 1);
    chk("w_scl", score_l, 15);
    chk("w_scr", score_r, 2);
    chk("w_ballrst", ball_reset, 1);
    chk("w_phys", phys_en, 0);
`endif
    tick();
    chk("over_hold", state, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_scl", score_l, 0);
    chk("restart_scr", score_r, 0);
    chk("restart_win", winner, 0);

    // reset during POINT with pause held
    run_point(10'd50);
    wait_leave(3'd3, n);
    wait_leave(3'd1, n);
    ball_y = 10'd230;
    tick();
    ball_y = 10'd0;
    chk("pre_rst_scr", score_r, 2);
    pause = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pause = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_scr", score_r, 0);
    chk("mid_rst_side", serve_side, 0);
    chk("mid_rst_ballrst", ball_reset, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
